// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: default operand width,
// FSM state encoding and the step-counter width helper.
package div_pkg;
    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } div_state_t;

    function automatic int step_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,q} left by one, subtract the divisor
// from the partial remainder when it fits and shift in the quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH-1:0] dvs,
    output logic [2*WIDTH:0] acc_next
);
    logic [WIDTH+1:0] rem_s;
    logic [WIDTH+1:0] diff;

    // diff sign bit is the borrow: set means the shifted remainder is below the divisor
    always_comb begin
        rem_s = {acc[2*WIDTH:WIDTH], acc[WIDTH-1]};
        diff  = rem_s - {2'b00, dvs};
        if (diff[WIDTH+1]) begin
            acc_next = {rem_s[WIDTH:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock, quotient -> LO, remainder -> HI.
// Define DIV_SIGNED_EN to honour is_signed (magnitude convert in, negate out); otherwise all operands are unsigned.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int            CW   = step_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH:0] acc;
    logic [2*WIDTH:0] acc_next;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] r_raw;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] dz_rem;

    div_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .dvs      (dvs),
        .acc_next (acc_next)
    );

    assign q_raw = acc_next[WIDTH-1:0];
    assign r_raw = acc_next[2*WIDTH-1:WIDTH];

`ifdef DIV_SIGNED_EN
    logic dvd_neg;
    logic dvs_neg;
    logic neg_q;
    logic neg_r;

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
    assign dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == S_IDLE && start) begin
            neg_q <= dvd_neg ^ dvs_neg;
            neg_r <= dvd_neg;
        end
    end

    assign q_fix  = neg_q ? (~q_raw + 1'b1) : q_raw;
    assign r_fix  = neg_r ? (~r_raw + 1'b1) : r_raw;
    // re-applying the dividend sign to its magnitude restores the latched dividend
    assign dz_rem = neg_r ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
`else
    logic unused_sign;
    assign unused_sign = is_signed;
    assign dvd_mag     = dividend;
    assign dvs_mag     = divisor;
    assign q_fix       = q_raw;
    assign r_fix       = r_raw;
    assign dz_rem      = acc[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            dvs         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc         <= {{(WIDTH+1){1'b0}}, dvd_mag};
                        dvs         <= dvs_mag;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        state       <= (divisor == '0) ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_FIN;
                    end
                end
                S_FIN: begin
                    // still busy here only on the divide-by-zero path, which publishes its result now
                    if (busy) begin
                        quotient    <= '1;
                        remainder   <= dz_rem;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (WIDTH=32), covering both the signed and unsigned builds.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

`ifdef DIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    always #5 clk = ~clk;

    div_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one division, wait (bounded) for done, check latency/results, then check the pulse ends.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz, input int elat);
        int lat;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = sg;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat      = 1;
        check({tag, ".busy_start"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".quotient"}, quotient, eq);
        check({tag, ".remainder"}, remainder, er);
        check({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(edz));
        check({tag, ".busy_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".q_hold"}, quotient, eq);
    endtask

    initial begin
        int pulses;
        int first;

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.quotient", quotient, 32'd0);
        check("rst.remainder", remainder, 32'd0);
        check("rst.div_by_zero", 32'(div_by_zero), 32'd0);
        reset = 1'b0;

        do_div("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
        do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1,
               SGN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, SGN ? 32'hFFFF_FFFF : 32'd1, 1'b0, 33);
        do_div("div_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1,
               SGN ? 32'hFFFF_FFF2 : 32'd0, SGN ? 32'd2 : 32'd100, 1'b0, 33);
        do_div("divu_by_zero", 32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 2);
        do_div("div_neg_by_zero", 32'hFFFF_FF00, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1, 2);
        do_div("div_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
               SGN ? 32'h8000_0000 : 32'd0, SGN ? 32'd0 : 32'h8000_0000, 1'b0, 33);
        do_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);

        // start pulse during an operation must be ignored
        @(negedge clk);
        dividend  = 32'd50;
        divisor   = 32'd5;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        first  = 0;
        for (int c = 1; c <= 45; c++) begin
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) first = c;
            end
            start = (c == 5);
            if (c == 5) begin
                dividend = 32'd9;
                divisor  = 32'd3;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("busy_start.pulses", 32'(pulses), 32'd1);
        check("busy_start.latency", 32'(first), 32'd33);
        check("busy_start.quotient_held", quotient, 32'd10);
        check("busy_start.remainder_held", remainder, 32'd0);
        check("busy_start.busy", 32'(busy), 32'd0);

        // reset in the middle of an operation
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd10;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_reset.busy", 32'(busy), 32'd0);
        check("mid_reset.done", 32'(done), 32'd0);
        check("mid_reset.quotient", quotient, 32'd0);
        check("mid_reset.remainder", remainder, 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) pulses++;
            @(posedge clk);
            #1;
        end
        check("mid_reset.no_done", 32'(pulses), 32'd0);
        do_div("after_reset", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
